// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: shifts two captured operands LSB-first through one
// full-adder slice with a registered carry, presenting {cout,sum} after WIDTH cycles.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic             carry_next;
  logic             sbit;
  logic [CNT_W-1:0] cnt;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder slice; new bit enters at the MSB so the sum assembles LSB-first.
  always_comb begin
    sbit       = a_sh[0] ^ b_sh[0] ^ carry;
    carry_next = majority(a_sh[0], b_sh[0], carry);
    s_next     = (s_sh >> 1) | (WIDTH'(sbit) << (WIDTH - 1));
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
          state <= RUN;
        end
      end else begin
        carry <= carry_next;
        s_sh  <= s_next;
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        cnt   <= cnt + 1'b1;
        // Last bit: publish the result on the same edge it is produced.
        if (cnt == LAST) begin
          sum   <= s_next;
          cout  <= carry_next;
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed and exhaustive checks of serial_adder_fsm at WIDTH = 8, 4 and 1.
module tb_serial_adder_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 0, cin8 = 0, busy8, done8, cout8;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic       start4 = 0, cin4 = 0, busy4, done4, cout4;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic       start1 = 0, cin1 = 0, busy1, done1, cout1;
  logic [0:0] a1 = 0, b1 = 0, sum1;

  serial_adder_fsm #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder_fsm #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
  serial_adder_fsm #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  int checks = 0;
  int failures = 0;
  int w_sel = 8;
  logic       sel_done, sel_busy;
  logic [8:0] sel_res;

  always_comb begin
    sel_done = done8;
    sel_busy = busy8;
    sel_res  = {cout8, sum8};
    if (w_sel == 4) begin
      sel_done = done4;
      sel_busy = busy4;
      sel_res  = {4'b0, cout4, sum4};
    end else if (w_sel == 1) begin
      sel_done = done1;
      sel_busy = busy1;
      sel_res  = {7'b0, cout1, sum1};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One start pulse; returns result, cycles until done, and cycles busy was seen.
  task automatic run_op(input int w, input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output logic [8:0] res, output int lat, output int nbusy);
    w_sel = w;
    case (w)
      8:       begin a8 = ta;      b8 = tb_v;      cin8 = tc; start8 = 1; end
      4:       begin a4 = ta[3:0]; b4 = tb_v[3:0]; cin4 = tc; start4 = 1; end
      default: begin a1 = ta[0];   b1 = tb_v[0];   cin1 = tc; start1 = 1; end
    endcase
    @(posedge clk); #1;
    start8 = 0; start4 = 0; start1 = 0;
    lat = 0;
    nbusy = 0;
    while (!sel_done && lat < 40) begin
      if (sel_busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    res = sel_res;
    check("done_busy_excl", {63'b0, sel_busy}, 64'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {63'b0, sel_done}, 64'd0);
  endtask

  logic [8:0] res;
  int lat, nb, ndone, dn;
  logic hold_ok;
  logic [8:0] got_res;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, busy8}, 0);
    check("rst_done", {63'b0, done8}, 0);
    check("rst_sum",  {56'b0, sum8}, 0);
    check("rst_cout", {63'b0, cout8}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    run_op(8, 8'h00, 8'h00, 1'b0, res, lat, nb);
    check("zero_res", res, 9'h000);
    check("zero_lat", lat, 8);
    check("zero_busy_cycles", nb, 8);
    run_op(8, 8'hFF, 8'h01, 1'b0, res, lat, nb);
    check("ff_01_res", res, 9'h100);
    run_op(8, 8'hA5, 8'h5A, 1'b1, res, lat, nb);
    check("a5_5a_c_res", res, 9'h100);
    run_op(8, 8'h3C, 8'h42, 1'b0, res, lat, nb);
    check("3c_42_res", res, 9'h07E);

    // Second start mid-run must be ignored; sum must hold 0x7E until done.
    w_sel = 8;
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    hold_ok = 1; ndone = 0; dn = 0; got_res = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin a8 = 8'hFF; b8 = 8'hFF; start8 = 1; end
      if (n == 3) start8 = 0;
      if (done8) begin
        ndone++;
        got_res = {cout8, sum8};
        dn = n;
      end else if (ndone == 0 && sum8 != 8'h7E) hold_ok = 0;
    end
    check("ign_done_count", ndone, 1);
    check("ign_res", got_res, 9'h030);
    check("ign_lat", dn, 8);
    check("ign_sum_hold", {63'b0, hold_ok}, 1);

    // Asynchronous reset mid-operation.
    a8 = 8'h80; b8 = 8'h80; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check("arst_busy", {63'b0, busy8}, 0);
    check("arst_done", {63'b0, done8}, 0);
    check("arst_sum",  {56'b0, sum8}, 0);
    check("arst_cout", {63'b0, cout8}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("arst_no_done", ndone, 0);
    run_op(8, 8'h01, 8'h01, 1'b0, res, lat, nb);
    check("arst_after_res", res, 9'h002);

    // start held high: one result every WIDTH+1 cycles.
    w_sel = 8;
    a8 = 8'h01; b8 = 8'h02; cin8 = 1; start8 = 1;
    @(posedge clk); #1;
    ndone = 0;
    for (int n = 1; n <= 40 && ndone < 3; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        check("b2b_res", {cout8, sum8}, 9'h004);
        check("b2b_when", n, 8 + 9 * (ndone - 1));
        check("b2b_excl", {63'b0, busy8}, 0);
      end
    end
    start8 = 0;
    check("b2b_count", ndone, 3);
    repeat (2) @(posedge clk);
    #1;

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          run_op(4, 8'(ia), 8'(ib), ic[0], res, lat, nb);
          check("w4_res", res, 9'(ia + ib + ic));
          check("w4_lat", lat, 4);
        end

    for (int ia = 0; ia < 2; ia++)
      for (int ib = 0; ib < 2; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          run_op(1, 8'(ia), 8'(ib), ic[0], res, lat, nb);
          check("w1_res", res, 9'(ia + ib + ic));
          check("w1_lat", lat, 1);
          check("w1_busy_cycles", nb, 1);
        end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
